// File: rtl/cache_ctrl_pkg.sv
// Shared state encoding and width helpers for the cache miss controller.
// Pure declarations: no latency, no flow control.
package cache_ctrl_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE      = 3'd0;
  localparam state_t LOOKUP    = 3'd1;
  localparam state_t WRITEBACK = 3'd2;
  localparam state_t FETCH     = 3'd3;
  localparam state_t FILL      = 3'd4;
  localparam state_t RESPOND   = 3'd5;

  localparam int MAX_AW = 64;

  // Way index width never collapses to zero, even for a direct-mapped cache.
  function automatic int waysWidth(input int numWays);
    return (numWays > 2) ? $clog2(numWays) : 1;
  endfunction

  function automatic int offsetWidth(input int blockSize);
    return $clog2(blockSize);
  endfunction

  function automatic logic [MAX_AW-1:0] block_align(input logic [MAX_AW-1:0] addr, input int off);
    logic [MAX_AW-1:0] mask;
    mask = '1 << off;
    return addr & mask;
  endfunction

endpackage

// File: rtl/cache_miss_controller_if.sv
// CPU, tag/data array and main-memory signals of the cache miss controller.
// master = controller side, slave = CPU/array/memory side.
interface cache_miss_controller_if #(
  parameter int NUM_WAYS      = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32
);
  import cache_ctrl_pkg::*;

  localparam int WW = waysWidth(NUM_WAYS);

  logic                     request;
  logic                     cpuWrite;
  logic [ADDRESS_WIDTH-1:0] cpuRequestAddress;
  logic [DATA_WIDTH-1:0]    dataFromRegister;
  logic [DATA_WIDTH-1:0]    dataToRegister;
  logic                     cpuReady;
  logic                     cpuError;

  logic                     lookupValid;
  logic [ADDRESS_WIDTH-1:0] lookupAddress;
  logic                     hit;
  logic [WW-1:0]            hitWay;
  logic [DATA_WIDTH-1:0]    readWord;
  logic [WW-1:0]            victimWay;
  logic                     victimValid;
  logic                     victimDirty;
  logic [ADDRESS_WIDTH-1:0] victimAddress;
  logic                     arrayWriteWord;
  logic [DATA_WIDTH-1:0]    writeWord;
  logic                     arrayFill;
  logic [WW-1:0]            arrayWay;

  logic                     memFetchReq;
  logic [ADDRESS_WIDTH-1:0] fetchAddress;
  logic                     memFetchAck;
  logic                     memWriteBackReq;
  logic [ADDRESS_WIDTH-1:0] writeBackAddress;
  logic                     memWriteBackAck;

  modport master (
    input  request, cpuWrite, cpuRequestAddress, dataFromRegister,
    input  hit, hitWay, readWord, victimWay, victimValid, victimDirty, victimAddress,
    input  memFetchAck, memWriteBackAck,
    output dataToRegister, cpuReady, cpuError,
    output lookupValid, lookupAddress, arrayWriteWord, writeWord, arrayFill, arrayWay,
    output memFetchReq, fetchAddress, memWriteBackReq, writeBackAddress
  );

  modport slave (
    output request, cpuWrite, cpuRequestAddress, dataFromRegister,
    output hit, hitWay, readWord, victimWay, victimValid, victimDirty, victimAddress,
    output memFetchAck, memWriteBackAck,
    input  dataToRegister, cpuReady, cpuError,
    input  lookupValid, lookupAddress, arrayWriteWord, writeWord, arrayFill, arrayWay,
    input  memFetchReq, fetchAddress, memWriteBackReq, writeBackAddress
  );

endinterface

// File: rtl/mem_timeout_counter.sv
// Bounds a memory handshake wait; expired flags the last allowed waiting cycle.
// A wait lasts at most 2**COUNTER_WIDTH-1 cycles; clear takes priority over enable.
module mem_timeout_counter #(
  parameter int COUNTER_WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  // Expires on the waiting cycle whose increment would bring the count to all ones.
  localparam logic [COUNTER_WIDTH-1:0] LAST = ~COUNTER_WIDTH'(1);

  logic [COUNTER_WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign expired = enable && (count == LAST);

endmodule

// File: rtl/cache_miss_controller.sv
// Blocking single-outstanding cache controller: lookup, dirty writeback, fetch, fill, replay.
// Hit completes 2 cycles after the request edge; requests arriving while busy are dropped.
module cache_miss_controller
  import cache_ctrl_pkg::*;
#(
  parameter int NUM_WAYS      = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int BLOCK_SIZE    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int COUNTER_WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  cache_miss_controller_if.master bus
);

  localparam int WW  = waysWidth(NUM_WAYS);
  localparam int OFF = offsetWidth(BLOCK_SIZE);

  state_t                   state;
  state_t                   nextState;
  logic [ADDRESS_WIDTH-1:0] reqAddress;
  logic [ADDRESS_WIDTH-1:0] victimAddressQ;
  logic [DATA_WIDTH-1:0]    storeData;
  logic [DATA_WIDTH-1:0]    loadData;
  logic [WW-1:0]            victimWayQ;
  logic                     reqWrite;
  logic                     replayed;
  logic                     failed;
  logic                     waiting;
  logic                     timerClear;
  logic                     timerExpired;
  logic                     storeHit;

  assign waiting  = (state == WRITEBACK) || (state == FETCH);
  assign storeHit = (state == LOOKUP) && bus.hit && reqWrite;

  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (bus.request) nextState = LOOKUP;
      end
      LOOKUP: begin
        if (bus.hit || replayed)                    nextState = RESPOND;
        else if (bus.victimValid && bus.victimDirty) nextState = WRITEBACK;
        else                                         nextState = FETCH;
      end
      WRITEBACK: begin
        if (bus.memWriteBackAck)   nextState = FETCH;
        else if (timerExpired)     nextState = RESPOND;
      end
      FETCH: begin
        if (bus.memFetchAck)       nextState = FILL;
        else if (timerExpired)     nextState = RESPOND;
      end
      FILL:    nextState = LOOKUP;
      RESPOND: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Restart the timeout on every entry into a memory wait, including WRITEBACK -> FETCH.
  assign timerClear = (nextState != state) && ((nextState == WRITEBACK) || (nextState == FETCH));

  mem_timeout_counter #(
    .COUNTER_WIDTH(COUNTER_WIDTH)
  ) timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timerClear),
    .enable  (waiting),
    .expired (timerExpired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      reqAddress     <= '0;
      reqWrite       <= 1'b0;
      storeData      <= '0;
      loadData       <= '0;
      victimWayQ     <= '0;
      victimAddressQ <= '0;
      replayed       <= 1'b0;
      failed         <= 1'b0;
    end else begin
      state <= nextState;
      case (state)
        IDLE: begin
          if (bus.request) begin
            reqAddress <= bus.cpuRequestAddress;
            reqWrite   <= bus.cpuWrite;
            storeData  <= bus.dataFromRegister;
            replayed   <= 1'b0;
            failed     <= 1'b0;
          end
        end
        LOOKUP: begin
          if (bus.hit) begin
            if (!reqWrite) loadData <= bus.readWord;
          end else if (replayed) begin
            // The freshly filled line still misses: give up instead of looping.
            failed <= 1'b1;
          end else begin
            victimWayQ     <= bus.victimWay;
            victimAddressQ <= bus.victimAddress;
          end
        end
        WRITEBACK: begin
          if (!bus.memWriteBackAck && timerExpired) failed <= 1'b1;
        end
        FETCH: begin
          if (!bus.memFetchAck && timerExpired) failed <= 1'b1;
        end
        FILL:    replayed <= 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.lookupValid      = (state == LOOKUP);
  assign bus.lookupAddress    = reqAddress;
  assign bus.arrayWriteWord   = storeHit;
  assign bus.writeWord        = storeData;
  assign bus.arrayFill        = (state == FILL);
  assign bus.arrayWay         = storeHit ? bus.hitWay : ((state == FILL) ? victimWayQ : '0);
  assign bus.memFetchReq      = (state == FETCH);
  assign bus.fetchAddress     = ADDRESS_WIDTH'(block_align(MAX_AW'(reqAddress), OFF));
  assign bus.memWriteBackReq  = (state == WRITEBACK);
  assign bus.writeBackAddress = victimAddressQ;
  assign bus.cpuReady         = (state == RESPOND);
  assign bus.cpuError         = (state == RESPOND) && failed;
  assign bus.dataToRegister   = loadData;

endmodule

// File: tb/tb_cache_miss_controller.sv
// Cycle-accurate bench: each transaction is expanded into a per-cycle schedule of
// environment inputs and expected controller outputs, then replayed and compared.
module tb_cache_miss_controller;

  localparam int CW = 3;
  localparam int TO = (1 << CW) - 1;

  localparam logic [6:0] S_LV   = 7'b1000000;
  localparam logic [6:0] S_RDY  = 7'b0100000;
  localparam logic [6:0] S_ERR  = 7'b0010000;
  localparam logic [6:0] S_FR   = 7'b0001000;
  localparam logic [6:0] S_WBR  = 7'b0000100;
  localparam logic [6:0] S_FILL = 7'b0000010;
  localparam logic [6:0] S_AWW  = 7'b0000001;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        firstHit;
    logic        replayHit;
    logic [1:0]  hway;
    logic [31:0] rword;
    logic [1:0]  vway;
    logic        vvalid;
    logic        vdirty;
    logic [31:0] vaddr;
    int          wbN;
    int          fN;
    int          rstAt;
    logic        busy;
    logic        stray;
  } txn_t;

  typedef struct {
    logic        chk;
    logic        rst;
    logic        req;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        hit;
    logic [1:0]  hway;
    logic [31:0] rword;
    logic [1:0]  vway;
    logic        vvalid;
    logic        vdirty;
    logic [31:0] vaddr;
    logic        fack;
    logic        wback;
    logic [6:0]  strobe;
    logic [1:0]  way;
    logic [31:0] expAddr;
    logic [31:0] expData;
    logic        zero;
  } cyc_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   passed = 0;
  int   total = 0;
  cyc_t plan[$];
  cyc_t tq[$];
  logic [31:0] lastLoad = '0;

  always #5 clk = ~clk;

  cache_miss_controller_if #(.NUM_WAYS(4), .DATA_WIDTH(32), .ADDRESS_WIDTH(32)) bus ();

  cache_miss_controller #(
    .NUM_WAYS(4), .DATA_WIDTH(32), .BLOCK_SIZE(32), .ADDRESS_WIDTH(32), .COUNTER_WIDTH(CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp, input int idx);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s at cycle %0d: got %h, required %h", name, idx, act, exp);
  endtask

  function automatic txn_t defTxn();
    txn_t t;
    t.wr = 1'b0; t.addr = '0; t.wdata = '0; t.firstHit = 1'b1; t.replayHit = 1'b1;
    t.hway = '0; t.rword = '0; t.vway = '0; t.vvalid = 1'b0; t.vdirty = 1'b0; t.vaddr = '0;
    t.wbN = 1; t.fN = 1; t.rstAt = 0; t.busy = 1'b0; t.stray = 1'b0;
    return t;
  endfunction

  // Environment inputs held for a transaction; busy cycles carry a bogus competing request.
  function automatic cyc_t baseCyc(input txn_t t);
    cyc_t c;
    c.chk = 1'b1; c.rst = 1'b0; c.req = t.busy; c.wr = ~t.wr;
    c.addr = 32'hFFFF_0000; c.wdata = 32'hFFFF_FFFF;
    c.hit = 1'b0; c.hway = t.hway; c.rword = t.rword;
    c.vway = t.vway; c.vvalid = t.vvalid; c.vdirty = t.vdirty; c.vaddr = t.vaddr;
    c.fack = 1'b0; c.wback = t.stray;
    c.strobe = '0; c.way = '0; c.expAddr = '0; c.expData = '0; c.zero = 1'b0;
    return c;
  endfunction

  function automatic cyc_t zeroCyc();
    cyc_t c;
    c = baseCyc(defTxn());
    c.req = 1'b0; c.wr = 1'b0; c.addr = '0; c.wdata = '0; c.zero = 1'b1;
    return c;
  endfunction

  task automatic pushLookup(input txn_t t, input logic hitNow);
    cyc_t c;
    c = baseCyc(t);
    c.strobe = S_LV; c.expAddr = t.addr; c.hit = hitNow;
    if (hitNow && t.wr) begin
      c.strobe = S_LV | S_AWW; c.way = t.hway; c.expData = t.wdata;
    end
    tq.push_back(c);
  endtask

  task automatic waitPhase(input txn_t t, input bit isWb, output bit ok);
    cyc_t c;
    int   n;
    n = isWb ? t.wbN : t.fN;
    ok = 1'b0;
    for (int k = 1; k <= TO && !ok; k++) begin
      c = baseCyc(t);
      if (isWb) begin
        c.strobe = S_WBR; c.wback = (k == n); c.expAddr = t.vaddr;
      end else begin
        c.strobe = S_FR; c.fack = (k == n); c.expAddr = {t.addr[31:5], 5'b0};
      end
      tq.push_back(c);
      if (k == n) ok = 1'b1;
    end
  endtask

  task automatic planTxn(input txn_t t, output int rdyAt);
    cyc_t c;
    bit   ok;
    tq.delete();
    c = baseCyc(t);
    c.req = 1'b1; c.wr = t.wr; c.addr = t.addr; c.wdata = t.wdata;
    tq.push_back(c);
    pushLookup(t, t.firstHit);
    ok = 1'b1;
    if (!t.firstHit) begin
      if (t.vvalid && t.vdirty) waitPhase(t, 1'b1, ok);
      if (ok) waitPhase(t, 1'b0, ok);
      if (ok) begin
        c = baseCyc(t);
        c.strobe = S_FILL; c.way = t.vway;
        tq.push_back(c);
        pushLookup(t, t.replayHit);
        ok = t.replayHit;
      end
    end
    c = baseCyc(t);
    c.strobe = ok ? S_RDY : (S_RDY | S_ERR);
    if (ok && !t.wr) lastLoad = t.rword;
    c.expData = lastLoad;
    rdyAt = tq.size();
    tq.push_back(c);
    c = baseCyc(t);
    c.req = 1'b0;
    tq.push_back(c);
    if (t.rstAt > 0) begin
      while (tq.size() > t.rstAt + 1) void'(tq.pop_back());
      c = tq[t.rstAt];
      c.rst = 1'b1;
      tq[t.rstAt] = c;
      lastLoad = '0;
      tq.push_back(zeroCyc());
      rdyAt = -1;
    end
    foreach (tq[i]) plan.push_back(tq[i]);
  endtask

  task automatic driveCyc(input cyc_t c);
    reset                 = c.rst;
    bus.request           = c.req;
    bus.cpuWrite          = c.wr;
    bus.cpuRequestAddress = c.addr;
    bus.dataFromRegister  = c.wdata;
    bus.hit               = c.hit;
    bus.hitWay            = c.hway;
    bus.readWord          = c.rword;
    bus.victimWay         = c.vway;
    bus.victimValid       = c.vvalid;
    bus.victimDirty       = c.vdirty;
    bus.victimAddress     = c.vaddr;
    bus.memFetchAck       = c.fack;
    bus.memWriteBackAck   = c.wback;
  endtask

  task automatic checkCyc(input cyc_t c, input int idx);
    logic [6:0] act;
    if (!c.chk) return;
    act = {bus.lookupValid, bus.cpuReady, bus.cpuError, bus.memFetchReq,
           bus.memWriteBackReq, bus.arrayFill, bus.arrayWriteWord};
    cmp("strobes", 32'(act), 32'(c.strobe), idx);
    if (c.strobe[1] || c.strobe[0]) cmp("arrayWay", 32'(bus.arrayWay), 32'(c.way), idx);
    if (c.strobe[6]) cmp("lookupAddress", bus.lookupAddress, c.expAddr, idx);
    if (c.strobe[3]) cmp("fetchAddress", bus.fetchAddress, c.expAddr, idx);
    if (c.strobe[2]) cmp("writeBackAddress", bus.writeBackAddress, c.expAddr, idx);
    if (c.strobe[0]) cmp("writeWord", bus.writeWord, c.expData, idx);
    if (c.strobe[5]) cmp("dataToRegister", bus.dataToRegister, c.expData, idx);
    if (c.zero) begin
      cmp("zero_dataToRegister", bus.dataToRegister, 32'h0, idx);
      cmp("zero_lookupAddress", bus.lookupAddress, 32'h0, idx);
      cmp("zero_fetchAddress", bus.fetchAddress, 32'h0, idx);
      cmp("zero_writeBackAddress", bus.writeBackAddress, 32'h0, idx);
      cmp("zero_writeWord", bus.writeWord, 32'h0, idx);
      cmp("zero_arrayWay", 32'(bus.arrayWay), 32'h0, idx);
    end
  endtask

  initial begin
    txn_t t;
    cyc_t c;
    int   r;
    int   nfr;

    c = zeroCyc();
    c.rst = 1'b1; c.chk = 1'b0;
    driveCyc(c);
    plan.push_back(c);
    plan.push_back(zeroCyc());

    // Load hit.
    t = defTxn(); t.addr = 32'h100; t.rword = 32'hDEADBEEF;
    planTxn(t, r); cmp("pin_hit_latency", 32'(r), 32'd2, -1);

    // Store hit into way 2.
    t = defTxn(); t.wr = 1'b1; t.addr = 32'h200; t.wdata = 32'hA5A5A5A5; t.hway = 2'd2;
    planTxn(t, r); cmp("pin_store_latency", 32'(r), 32'd2, -1);

    // Clean miss, fetch acked on the third request cycle.
    t = defTxn(); t.addr = 32'h1234; t.firstHit = 1'b0; t.vway = 2'd1; t.fN = 3; t.rword = 32'h12345678;
    planTxn(t, r); cmp("pin_clean_latency", 32'(r), 32'd7, -1);
    cmp("pin_fetchAddress", tq[2].expAddr, 32'h0000_1220, -1);

    // Dirty miss store, immediate acks, competing requests while busy.
    t = defTxn(); t.wr = 1'b1; t.addr = 32'h4444; t.wdata = 32'hCAFEF00D; t.firstHit = 1'b0;
    t.hway = 2'd3; t.vway = 2'd3; t.vvalid = 1'b1; t.vdirty = 1'b1; t.vaddr = 32'h8000; t.busy = 1'b1;
    planTxn(t, r); cmp("pin_dirty_latency", 32'(r), 32'd6, -1);

    // Fetch never acked, with a stray writeback ack throughout: timeout error.
    t = defTxn(); t.addr = 32'h3000; t.firstHit = 1'b0; t.fN = 0; t.stray = 1'b1; t.rword = 32'h0;
    planTxn(t, r); cmp("pin_timeout_latency", 32'(r), 32'd9, -1);
    nfr = 0;
    foreach (tq[i]) if (tq[i].strobe == S_FR) nfr++;
    cmp("pin_timeout_fetch_cycles", 32'(nfr), 32'd7, -1);

    // Next request after a timeout is served normally.
    t = defTxn(); t.addr = 32'h104; t.rword = 32'h0BADF00D;
    planTxn(t, r);

    // Valid clean victim, line still misses after the fill.
    t = defTxn(); t.addr = 32'h2468; t.firstHit = 1'b0; t.replayHit = 1'b0;
    t.vvalid = 1'b1; t.vway = 2'd2; t.fN = 2; t.rword = 32'h55AA55AA;
    planTxn(t, r);

    // Dirty victim whose writeback is never acked.
    t = defTxn(); t.addr = 32'h7000; t.firstHit = 1'b0; t.vvalid = 1'b1; t.vdirty = 1'b1;
    t.vaddr = 32'h9000; t.wbN = 0;
    planTxn(t, r);

    // Reset in the second fetch cycle while competing requests are pulsed.
    t = defTxn(); t.addr = 32'h5000; t.firstHit = 1'b0; t.fN = 0; t.busy = 1'b1;
    t.rstAt = 3;
    planTxn(t, r);

    // Hit after reset with competing requests.
    t = defTxn(); t.addr = 32'h600; t.rword = 32'h600DCAFE; t.busy = 1'b1;
    planTxn(t, r);

    foreach (plan[i]) begin
      @(posedge clk);
      #1;
      driveCyc(plan[i]);
      @(negedge clk);
      checkCyc(plan[i], i);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
